// File: rtl/amber_pkg.sv
// Shared constants and bank encoding for the register writeback path.
// Also holds a helper that maps {bank, index} onto a scoreboard bit.
package amber_pkg;

  localparam int DATA_W = 48;
  localparam int AW     = 3;
  localparam int NREG   = 1 << AW;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_D = 1'b1
  } bank_e;

  // Scoreboard layout: A registers in the low half, D registers in the high half.
  function automatic logic [2*NREG-1:0] reg_bit(input logic bank, input logic [AW-1:0] addr);
    logic [2*NREG-1:0] m;
    m = '0;
    m[{bank, addr}] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regwb_arb_if.sv
// Writeback sources (ALU, load unit) and decode-issue marking, grouped as one bundle.
// Handshake: a beat moves when valid and ready are both high at a rising clk edge;
// ready never depends on its own valid, and a source may change its beat only after it moves.
interface regwb_arb_if #(
  parameter int DATA_W = 48,
  parameter int AW     = 3
);

  logic              s0_valid;
  logic              s0_ready;
  logic              s0_bank;
  logic [AW-1:0]     s0_addr;
  logic [DATA_W-1:0] s0_data;

  logic              s1_valid;
  logic              s1_ready;
  logic              s1_bank;
  logic [AW-1:0]     s1_addr;
  logic [DATA_W-1:0] s1_data;

  logic              iss_valid;
  logic              iss_bank;
  logic [AW-1:0]     iss_addr;

  modport master (
    output s0_valid, s0_bank, s0_addr, s0_data,
    input  s0_ready,
    output s1_valid, s1_bank, s1_addr, s1_data,
    input  s1_ready,
    output iss_valid, iss_bank, iss_addr
  );

  modport slave (
    input  s0_valid, s0_bank, s0_addr, s0_data,
    output s0_ready,
    input  s1_valid, s1_bank, s1_addr, s1_data,
    output s1_ready,
    input  iss_valid, iss_bank, iss_addr
  );

endinterface

// File: rtl/regwb_arb_rr_arb2.sv
// Two-requester round-robin arbiter with a 1-bit pointer (0 = requester 0 preferred).
// Grants are readiness: each depends only on the other requester and the pointer.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic ptr
);

  assign gnt0 = !req1 || !ptr;
  assign gnt1 = !req0 ||  ptr;

  // Under contention exactly one grant is high and its requester is valid,
  // so a beat always moves and the pointer can flip unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (req0 && req1) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/regwb_arb.sv
// Writeback arbiter: merges two sources onto the A and D register-file write ports
// and keeps a pending-write scoreboard set by decode and cleared by writeback.
module regwb_arb #(
  parameter int DATA_W = amber_pkg::DATA_W,
  parameter int AW     = amber_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  regwb_arb_if.slave        bus,
  output logic              a_we,
  output logic [AW-1:0]     a_waddr,
  output logic [DATA_W-1:0] a_wdata,
  output logic              d_we,
  output logic [AW-1:0]     d_waddr,
  output logic [DATA_W-1:0] d_wdata,
  output logic [15:0]       busy,
  output logic [1:0]        dbg_ptr
);

  import amber_pkg::*;

  logic a_req0, a_req1, d_req0, d_req1;
  logic a_gnt0, a_gnt1, d_gnt0, d_gnt1;
  logic a_ptr, d_ptr;

  assign a_req0 = bus.s0_valid && (bus.s0_bank == BANK_A);
  assign a_req1 = bus.s1_valid && (bus.s1_bank == BANK_A);
  assign d_req0 = bus.s0_valid && (bus.s0_bank == BANK_D);
  assign d_req1 = bus.s1_valid && (bus.s1_bank == BANK_D);

  rr_arb2 u_arb_a (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (a_req0),
    .req1 (a_req1),
    .gnt0 (a_gnt0),
    .gnt1 (a_gnt1),
    .ptr  (a_ptr)
  );

  rr_arb2 u_arb_d (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (d_req0),
    .req1 (d_req1),
    .gnt0 (d_gnt0),
    .gnt1 (d_gnt1),
    .ptr  (d_ptr)
  );

  assign dbg_ptr = {d_ptr, a_ptr};

  assign bus.s0_ready = (bus.s0_bank == BANK_A) ? a_gnt0 : d_gnt0;
  assign bus.s1_ready = (bus.s1_bank == BANK_A) ? a_gnt1 : d_gnt1;

  logic t0, t1;
  assign t0 = bus.s0_valid && bus.s0_ready;
  assign t1 = bus.s1_valid && bus.s1_ready;

  // Arbitration guarantees at most one transfer per bank per cycle.
  logic              a_sel0, a_sel1, d_sel0, d_sel1;
  logic [AW-1:0]     a_nxt_addr, d_nxt_addr;
  logic [DATA_W-1:0] a_nxt_data, d_nxt_data;
  logic              a_write, d_write;

  assign a_sel0     = t0 && (bus.s0_bank == BANK_A);
  assign a_sel1     = t1 && (bus.s1_bank == BANK_A);
  assign d_sel0     = t0 && (bus.s0_bank == BANK_D);
  assign d_sel1     = t1 && (bus.s1_bank == BANK_D);
  assign a_nxt_addr = a_sel0 ? bus.s0_addr : bus.s1_addr;
  assign a_nxt_data = a_sel0 ? bus.s0_data : bus.s1_data;
  assign d_nxt_addr = d_sel0 ? bus.s0_addr : bus.s1_addr;
  assign d_nxt_data = d_sel0 ? bus.s0_data : bus.s1_data;

  // A-bank register 0 is hardwired: the beat is accepted but never written.
  assign a_write = (a_sel0 || a_sel1) && (a_nxt_addr != '0);
  assign d_write = d_sel0 || d_sel1;

  logic [15:0] busy_clr, busy_set;
  assign busy_clr = (t0 ? reg_bit(bus.s0_bank, bus.s0_addr) : 16'h0000)
                  | (t1 ? reg_bit(bus.s1_bank, bus.s1_addr) : 16'h0000);
  assign busy_set = (bus.iss_valid && !(bus.iss_bank == BANK_A && bus.iss_addr == '0))
                  ? reg_bit(bus.iss_bank, bus.iss_addr) : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_we    <= 1'b0;
      a_waddr <= '0;
      a_wdata <= '0;
      d_we    <= 1'b0;
      d_waddr <= '0;
      d_wdata <= '0;
      busy    <= 16'h0000;
    end else begin
      a_we <= a_write;
      d_we <= d_write;
      if (a_write) begin
        a_waddr <= a_nxt_addr;
        a_wdata <= a_nxt_data;
      end
      if (d_write) begin
        d_waddr <= d_nxt_addr;
        d_wdata <= d_nxt_data;
      end
      // Set after clear so a fresh issue survives a same-edge writeback.
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

endmodule

// File: tb/tb_regwb_arb.sv
// Bench for regwb_arb: directed vector table, hand sequences for scoreboard and
// async reset, then random traffic against a rule-level reference model.
module tb_regwb_arb;

  localparam int DW = 48;
  localparam int AWB = 3;

  logic clk;
  logic rst_n;
  logic            a_we, d_we;
  logic [AWB-1:0]  a_waddr, d_waddr;
  logic [DW-1:0]   a_wdata, d_wdata;
  logic [15:0]     busy;
  logic [1:0]      dbg_ptr;

  regwb_arb_if #(.DATA_W(DW), .AW(AWB)) bus ();

  regwb_arb #(.DATA_W(DW), .AW(AWB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .a_we   (a_we),
    .a_waddr(a_waddr),
    .a_wdata(a_wdata),
    .d_we   (d_we),
    .d_waddr(d_waddr),
    .d_wdata(d_wdata),
    .busy   (busy),
    .dbg_ptr(dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           s0v;
    logic           s0b;
    logic [AWB-1:0] s0a;
    logic [DW-1:0]  s0d;
    logic           s1v;
    logic           s1b;
    logic [AWB-1:0] s1a;
    logic [DW-1:0]  s1d;
    logic           iv;
    logic           ib;
    logic [AWB-1:0] ia;
    logic           e0;
    logic           e1;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit             m_ptr [2];
  bit             m_busy[16];
  logic           m_awe, m_dwe;
  logic [AWB-1:0] m_awaddr, m_dwaddr;
  logic [DW-1:0]  m_awdata, m_dwdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr[0] = 0;
    m_ptr[1] = 0;
    for (int i = 0; i < 16; i++) m_busy[i] = 0;
    m_awe = 0; m_awaddr = '0; m_awdata = '0;
    m_dwe = 0; m_dwaddr = '0; m_dwdata = '0;
  endfunction

  // A source is ready unless the other source contends for its bank and the
  // bank's turn belongs to the other source.
  function automatic logic model_ready(input vec_t v, input int src);
    if (src == 0) begin
      if (v.s1v && v.s1b == v.s0b) return (m_ptr[v.s0b] == 0);
      return 1'b1;
    end
    if (v.s0v && v.s0b == v.s1b) return (m_ptr[v.s1b] == 1);
    return 1'b1;
  endfunction

  function automatic void model_write(input logic b, input logic [AWB-1:0] a, input logic [DW-1:0] d);
    if (b == 1'b0) begin
      if (a != 0) begin
        m_awe = 1; m_awaddr = a; m_awdata = d;
      end
    end else begin
      m_dwe = 1; m_dwaddr = a; m_dwdata = d;
    end
    m_busy[int'(b) * 8 + int'(a)] = 0;
  endfunction

  function automatic void model_edge(input vec_t v, input logic r0, input logic r1);
    m_awe = 0;
    m_dwe = 0;
    if (v.s0v && r0) model_write(v.s0b, v.s0a, v.s0d);
    if (v.s1v && r1) model_write(v.s1b, v.s1a, v.s1d);
    if (v.s0v && v.s1v && v.s0b == v.s1b) m_ptr[v.s0b] = !m_ptr[v.s0b];
    if (v.iv && !(v.ib == 1'b0 && v.ia == 0)) m_busy[int'(v.ib) * 8 + int'(v.ia)] = 1;
  endfunction

  task automatic check_outputs();
    logic [15:0] eb;
    for (int i = 0; i < 16; i++) eb[i] = m_busy[i];
    chk("a_we", a_we, m_awe);
    chk("a_waddr", a_waddr, m_awaddr);
    chk("a_wdata", a_wdata, m_awdata);
    chk("d_we", d_we, m_dwe);
    chk("d_waddr", d_waddr, m_dwaddr);
    chk("d_wdata", d_wdata, m_dwdata);
    chk("busy", busy, eb);
    chk("ptr", dbg_ptr, {m_ptr[1], m_ptr[0]});
  endtask

  // driver
  task automatic drive(input vec_t v);
    bus.s0_valid  = v.s0v; bus.s0_bank = v.s0b; bus.s0_addr = v.s0a; bus.s0_data = v.s0d;
    bus.s1_valid  = v.s1v; bus.s1_bank = v.s1b; bus.s1_addr = v.s1a; bus.s1_data = v.s1d;
    bus.iss_valid = v.iv;  bus.iss_bank = v.ib; bus.iss_addr = v.ia;
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{1'b0, 1'b0, 3'd0, 48'h0, 1'b0, 1'b0, 3'd0, 48'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit use_exp);
    logic r0, r1;
    @(negedge clk);
    drive(v);
    #1;
    r0 = model_ready(v, 0);
    r1 = model_ready(v, 1);
    chk("s0_ready", bus.s0_ready, r0);
    chk("s1_ready", bus.s1_ready, r1);
    if (use_exp) begin
      chk("tbl_s0_ready", bus.s0_ready, v.e0);
      chk("tbl_s1_ready", bus.s1_ready, v.e1);
    end
    @(posedge clk);
    model_edge(v, r0, r1);
    #1;
    check_outputs();
  endtask

  vec_t tbl[11];
  vec_t v;

  initial begin
    //              s0v  s0b  s0a   s0d          s1v  s1b  s1a   s1d          iv   ib   ia    e0   e1
    tbl[0]  = '{1'b1,1'b0,3'd3,48'h1234,      1'b1,1'b1,3'd5,48'hABCD,      1'b0,1'b0,3'd0,1'b1,1'b1};
    tbl[1]  = '{1'b0,1'b0,3'd0,48'h0,         1'b0,1'b0,3'd0,48'h0,         1'b0,1'b0,3'd0,1'b1,1'b1};
    tbl[2]  = '{1'b1,1'b1,3'd1,48'h111111,    1'b1,1'b1,3'd2,48'h222222,    1'b0,1'b0,3'd0,1'b1,1'b0};
    tbl[3]  = '{1'b1,1'b1,3'd1,48'h111111,    1'b1,1'b1,3'd2,48'h222222,    1'b0,1'b0,3'd0,1'b0,1'b1};
    tbl[4]  = '{1'b1,1'b1,3'd1,48'h333333,    1'b1,1'b1,3'd2,48'h222222,    1'b0,1'b0,3'd0,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b1,3'd1,48'h333333,    1'b1,1'b1,3'd2,48'h444444,    1'b0,1'b0,3'd0,1'b0,1'b1};
    tbl[6]  = '{1'b0,1'b0,3'd0,48'h0,         1'b1,1'b0,3'd4,48'h4444,      1'b0,1'b0,3'd0,1'b1,1'b1};
    tbl[7]  = '{1'b1,1'b0,3'd0,48'hFFFF,      1'b0,1'b1,3'd0,48'h0,         1'b0,1'b0,3'd0,1'b1,1'b1};
    tbl[8]  = '{1'b1,1'b0,3'd1,48'hA1A1,      1'b1,1'b0,3'd6,48'hB6B6,      1'b0,1'b0,3'd0,1'b1,1'b0};
    tbl[9]  = '{1'b0,1'b0,3'd1,48'h0,         1'b1,1'b0,3'd6,48'hB6B6,      1'b0,1'b0,3'd0,1'b0,1'b1};
    tbl[10] = '{1'b1,1'b0,3'd1,48'hC1C1,      1'b1,1'b0,3'd6,48'hD6D6,      1'b0,1'b0,3'd0,1'b0,1'b1};

    rst_n = 1'b0;
    drive(idle_vec());
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_s0_ready", bus.s0_ready, 1'b1);
    chk("rst_s1_ready", bus.s1_ready, 1'b1);
    check_outputs();

    // directed table
    for (int i = 0; i < 11; i++) run_vec(tbl[i], 1'b1);

    // scoreboard: issue A2, wait, write back A2
    v = idle_vec(); v.iv = 1; v.ib = 0; v.ia = 3'd2;
    run_vec(v, 1'b0);
    chk("busy_a2_set", busy[2], 1'b1);
    run_vec(idle_vec(), 1'b0);
    run_vec(idle_vec(), 1'b0);
    chk("busy_a2_held", busy[2], 1'b1);
    v = idle_vec(); v.s1v = 1; v.s1b = 0; v.s1a = 3'd2; v.s1d = 48'h5A5A;
    run_vec(v, 1'b0);
    chk("busy_a2_clr", busy[2], 1'b0);
    v.iv = 1; v.ib = 0; v.ia = 3'd2; v.s1d = 48'h6B6B;
    run_vec(v, 1'b0);
    chk("busy_a2_set_wins", busy[2], 1'b1);
    v = idle_vec(); v.iv = 1; v.ib = 0; v.ia = 3'd0;
    run_vec(v, 1'b0);
    chk("busy_a0_never", busy[0], 1'b0);
    v = idle_vec(); v.s0v = 1; v.s0b = 0; v.s0a = 3'd0; v.s0d = 48'hFFFF;
    run_vec(v, 1'b0);
    chk("a0_no_we", a_we, 1'b0);

    // async reset right after a transfer, with busy and a pointer non-zero
    v = idle_vec();
    v.s0v = 1; v.s0b = 0; v.s0a = 3'd5; v.s0d = 48'h5555;
    v.s1v = 1; v.s1b = 0; v.s1a = 3'd6; v.s1d = 48'h6666;
    v.iv = 1; v.ib = 1; v.ia = 3'd7;
    run_vec(v, 1'b0);
    chk("pre_rst_a_we", a_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_a_we", a_we, 1'b0);
    chk("async_busy", busy, 16'h0000);
    model_reset();
    @(negedge clk);
    drive(idle_vec());
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ptr", dbg_ptr, 2'b00);
    check_outputs();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      v = idle_vec();
      v.s0v = ($urandom_range(0, 3) != 0);
      v.s0b = 1'($urandom_range(0, 1));
      v.s0a = 3'($urandom_range(0, 7));
      v.s0d = {16'($urandom), 32'($urandom)};
      v.s1v = ($urandom_range(0, 3) != 0);
      v.s1b = 1'($urandom_range(0, 1));
      v.s1a = 3'($urandom_range(0, 7));
      v.s1d = {16'($urandom), 32'($urandom)};
      v.iv  = ($urandom_range(0, 1) != 0);
      v.ib  = 1'($urandom_range(0, 1));
      v.ia  = 3'($urandom_range(0, 7));
      run_vec(v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regwb_arb.md
REGWB_ARB -- requirements
Module: regwb_arb

Interface
REQ-001 Parameter DATA_W, default 48, register data width.
REQ-002 Parameter AW, default 3, register index width (8 registers per bank).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s0_valid/s0_ready  input/output  1/1  source 0 (ALU) writeback handshake.
REQ-006 s0_bank  s0_addr  s0_data  input  1/AW/DATA_W  target bank (0=A, 1=D), index, value.
REQ-007 s1_valid/s1_ready, s1_bank, s1_addr, s1_data  same widths as s0; source 1 (load unit).
REQ-008 iss_valid  iss_bank  iss_addr  input  1/1/AW  decode marks a destination register as pending.
REQ-009 a_we  a_waddr  a_wdata  output  1/AW/DATA_W  A-bank write port drive.
REQ-010 d_we  d_waddr  d_wdata  output  1/AW/DATA_W  D-bank write port drive.
REQ-011 busy  output  16  pending-write scoreboard; bit[7:0]=A regs, bit[15:8]=D regs.

Function
REQ-012 A beat transfers on source s when s_valid and s_ready are both high at a rising edge.
REQ-013 s_ready is combinational from the other source's valid/bank and the bank's priority pointer; it does not depend on its own s_valid.
REQ-014 Sources targeting different banks: both ready high; both transfer in the same cycle.
REQ-015 Both sources valid on the same bank: exactly one is ready, chosen by that bank's 1-bit round-robin pointer.
REQ-016 Per-bank pointer toggles after a transfer won under contention only; an uncontended transfer leaves it unchanged.
REQ-017 Only one source valid: that source is ready regardless of the pointer.
REQ-018 Bank write outputs are registered: a transfer at edge N drives we/waddr/wdata for the cycle after edge N, so the register file commits at edge N+1.
REQ-019 we deasserts in any cycle following an edge with no transfer to that bank; waddr/wdata hold their last values.
REQ-020 A transfer to A-bank index 0 completes normally (ready high) but does not assert a_we and clears no busy bit.
REQ-021 busy bit set at the edge where iss_valid is high for {bank,addr}; iss_bank=0,iss_addr=0 sets nothing.
REQ-022 busy bit cleared at the edge where a transfer for {bank,addr} occurs.
REQ-023 Set and clear of the same bit at the same edge: bit ends set.
REQ-024 Setting an already-set bit or clearing an already-clear bit is harmless; no error reported.
REQ-025 Pointer width 1 per bank, no other counters; no backpressure from register file (write port always accepts).

Reset
REQ-026 rst_n low: a_we=0, d_we=0, a_waddr=d_waddr=0, a_wdata=d_wdata=0, busy=16'h0000, both pointers=0 (source 0 preferred).
REQ-027 Reset asserted mid-operation drops any registered write (we=0 immediately, asynchronously); beats not yet transferred remain the sources' responsibility.
REQ-028 s0_ready/s1_ready follow REQ-013..017 combinationally even during reset; no transfer state updates while rst_n low.

Structure
REQ-029 Shared package amber_pkg holds DATA_W/AW constants and the bank encoding (BANK_A=0, BANK_D=1).
REQ-030 One sub-module rr_arb2: 2-requester round-robin arbiter with grant outputs and pointer register; instantiated once per bank.
REQ-031 Target size 150-300 lines RTL.

Verification
REQ-032 Reset, then no stimulus -> a_we=d_we=0, busy=0, s0_ready=s1_ready=1.
REQ-033 s0 {A,3,48'h1234} and s1 {D,5,48'hABCD} same cycle -> both transfer; next cycle a_we=1/a_waddr=3/a_wdata=1234 and d_we=1/d_waddr=5/d_wdata=ABCD.
REQ-034 s0 and s1 both held valid on bank D for 4 cycles -> grants alternate s0,s1,s0,s1; d_we high 4 consecutive cycles.
REQ-035 iss {A,2}; 3 cycles later s1 writes {A,2} -> busy[2] high from edge after iss until edge of transfer, then low; with iss {A,2} coinciding with transfer, busy[2] stays high.
REQ-036 s0 writes {A,0,48'hFFFF} -> s0_ready=1, a_we stays 0, busy unchanged.
REQ-037 rst_n dropped the cycle after a transfer -> a_we falls immediately; busy=0 and pointers=0 after release.
